// File: rtl/lsh_pkg.sv
// Shared types and constants for the minhash / LSH pipeline stages.
package lsh_pkg;

   typedef logic [1:0] base_t;

   localparam base_t BASE_A = 2'b00;
   localparam base_t BASE_C = 2'b01;
   localparam base_t BASE_G = 2'b10;
   localparam base_t BASE_T = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SCAN,
      ST_FLUSH,
      ST_DONE
   } kmer_minhash_state_e;

   localparam logic [31:0] DEF_HASH_MULT = 32'h9E3779B1;

endpackage

// File: rtl/kmer_hash.sv
// Combinational multiplicative k-mer hash; shared with the LSH table stage.
module kmer_hash #(
   parameter int                 KW        = 32,
   parameter int                 HASH_W    = 32,
   parameter logic [31:0]        HASH_MULT = 32'h9E3779B1,
   parameter logic [HASH_W-1:0]  HASH_SEED = '0
) (
   input  logic [KW-1:0]      kmer,
   output logic [HASH_W-1:0]  hash
);

   // Low product bits depend only on low operand bits, so multiply at HASH_W.
   logic [HASH_W-1:0] a;
   logic [HASH_W-1:0] b;

   assign a    = HASH_W'(kmer);
   assign b    = HASH_W'(HASH_MULT);
   assign hash = (a * b) ^ HASH_SEED;

endmodule

// File: rtl/kmer_minhash.sv
// Slides a k-mer over a latched window, one base per clock, and reports the minimum hash and its start.
//  state    | meaning
//  ST_IDLE  | waiting for ready_for_hashing, captures window on request
//  ST_SCAN  | shifting one base per edge into the k-mer register
//  ST_FLUSH | compares the final k-mer, loads res_*, pulses res_valid
//  ST_DONE  | hashing_is_done held until ready_for_hashing drops
module kmer_minhash
   import lsh_pkg::*;
#(
   parameter int                 WINDOW_SIZE = 128,
   parameter int                 KMER_SIZE   = 16,
   parameter int                 ID_W        = 16,
   parameter int                 HASH_W      = 32,
   parameter logic [31:0]        HASH_MULT   = DEF_HASH_MULT,
   parameter logic [HASH_W-1:0]  HASH_SEED   = '0
) (
   input  logic                            clk,
   input  logic                            rst,
   input  base_t                           window [0:WINDOW_SIZE-1],
   input  logic [ID_W-1:0]                 window_id,
   input  logic                            is_insert,
   input  logic                            window_reset,
   input  logic                            ready_for_hashing,
   output logic                            hashing_is_done,
   output logic                            res_valid,
   output logic [HASH_W-1:0]               res_min_hash,
   output logic [$clog2(WINDOW_SIZE)-1:0]  res_min_pos,
   output logic [ID_W-1:0]                 res_window_id,
   output logic                            res_is_insert
);

   localparam int                KW       = 2 * KMER_SIZE;
   localparam int                POS_W    = $clog2(WINDOW_SIZE);
   localparam logic [POS_W-1:0]  IDX_LAST = POS_W'(WINDOW_SIZE - 1);
   localparam logic [POS_W-1:0]  K_LAST   = POS_W'(KMER_SIZE - 1);

   if (KMER_SIZE > WINDOW_SIZE) begin : g_size_check
      $error("kmer_minhash: KMER_SIZE must not exceed WINDOW_SIZE");
   end

   kmer_minhash_state_e   state;
   base_t                 win_buf [0:WINDOW_SIZE-1];
   logic [POS_W-1:0]      idx;
   logic [POS_W-1:0]      kmer_pos;
   logic [KW-1:0]         kmer;
   logic                  kmer_vld;
   logic                  first;
   logic [HASH_W-1:0]     min_hash;
   logic [POS_W-1:0]      min_pos;
   logic [HASH_W-1:0]     h;
   logic [HASH_W-1:0]     min_nxt;
   logic [POS_W-1:0]      pos_nxt;
   logic [ID_W-1:0]       id_q;
   logic                  ins_q;
   logic                  capture;

   kmer_hash #(
      .KW        (KW),
      .HASH_W    (HASH_W),
      .HASH_MULT (HASH_MULT),
      .HASH_SEED (HASH_SEED)
   ) u_hash (
      .kmer (kmer),
      .hash (h)
   );

   assign capture = (state == ST_IDLE) && ready_for_hashing && !hashing_is_done
                    && !window_reset && !rst;

   always_ff @(posedge clk) begin
      if (capture) win_buf <= window;
   end

   // Strict less-than keeps the earlier position on ties.
   always_comb begin
      min_nxt = min_hash;
      pos_nxt = min_pos;
      if (kmer_vld && (first || (h < min_hash))) begin
         min_nxt = h;
         pos_nxt = kmer_pos;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || window_reset) begin
         state           <= ST_IDLE;
         idx             <= '0;
         kmer_pos        <= '0;
         kmer            <= '0;
         kmer_vld        <= 1'b0;
         first           <= 1'b1;
         min_hash        <= '1;
         min_pos         <= '0;
         id_q            <= '0;
         ins_q           <= 1'b0;
         hashing_is_done <= 1'b0;
         res_valid       <= 1'b0;
         res_min_hash    <= '0;
         res_min_pos     <= '0;
         res_window_id   <= '0;
         res_is_insert   <= 1'b0;
      end else begin
         res_valid <= 1'b0;
         if (kmer_vld) begin
            min_hash <= min_nxt;
            min_pos  <= pos_nxt;
            first    <= 1'b0;
         end
         case (state)
            ST_IDLE: begin
               if (capture) begin
                  state    <= ST_SCAN;
                  idx      <= '0;
                  kmer     <= '0;
                  kmer_vld <= 1'b0;
                  first    <= 1'b1;
                  min_hash <= '1;
                  min_pos  <= '0;
                  id_q     <= window_id;
                  ins_q    <= is_insert;
               end
            end
            ST_SCAN: begin
               kmer     <= {kmer[KW-3:0], win_buf[idx]};
               kmer_vld <= (idx >= K_LAST);
               kmer_pos <= idx - K_LAST;
               if (idx == IDX_LAST) state <= ST_FLUSH;
               else                 idx   <= idx + 1'b1;
            end
            ST_FLUSH: begin
               kmer_vld        <= 1'b0;
               res_min_hash    <= min_nxt;
               res_min_pos     <= pos_nxt;
               res_window_id   <= id_q;
               res_is_insert   <= ins_q;
               res_valid       <= 1'b1;
               hashing_is_done <= 1'b1;
               state           <= ST_DONE;
            end
            ST_DONE: begin
               if (!ready_for_hashing) begin
                  hashing_is_done <= 1'b0;
                  state           <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
